// File: rtl/enc_mod_xor_seq.sv
// enc_mod_xor_seq
//   Multi-cycle encryption stage. Reduces the exponent result modulo p with a
//   bit-serial restoring reducer (one exponent bit per clock, MSB first), then
//   masks the key with r to form the cipher word. A p of zero skips the
//   reduction and reports err.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, sampled only while idle
//   exp_i  dividend (DW bits)
//   p_i    modulus (PW bits)
//   r_i    mask XORed into the key (DW bits)
//   busy   reduction in progress
//   done   one-cycle completion pulse; k_o/c_o/err valid from this cycle
//   err    modulus was zero for the accepted request
//   k_o    exp mod p, zero-extended
//   c_o    k_o ^ r
//
// State  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start; results held
// CALC   | shifting one exponent bit per clock into rem
// ZERO   | single cycle reporting divide-by-zero
module enc_mod_xor_seq #(
  parameter int DW = 64,
  parameter int PW = 32,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] exp_i,
  input  logic [PW-1:0] p_i,
  input  logic [DW-1:0] r_i,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] k_o,
  output logic [DW-1:0] c_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ZERO = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [PW-1:0] mod_q,   mod_d;
  logic [DW-1:0] mask_q,  mask_d;
  logic [PW-1:0] rem_q,   rem_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          err_q,   err_d;
  logic [DW-1:0] k_q,     k_d;
  logic [DW-1:0] c_q,     c_d;

  // One restoring step: bring in the next exponent bit and subtract the
  // modulus if it fits. Because rem < mod always holds, t fits in PW+1 bits
  // and the restored value always fits back into PW bits.
  logic [PW:0]   t;
  logic [PW:0]   t_sub;
  logic          t_ge;
  logic [PW-1:0] rem_nxt;
  logic          last_bit;

  always_comb begin
    t        = {rem_q, shift_q[DW-1]};
    t_sub    = t - {1'b0, mod_q};
    t_ge     = (t >= {1'b0, mod_q});
    rem_nxt  = t_ge ? t_sub[PW-1:0] : t[PW-1:0];
    last_bit = (cnt_q == CW'(DW-1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      mod_q   <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mod_q   <= mod_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      k_q     <= k_d;
      c_q     <= c_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mod_d   = mod_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    k_d     = k_q;
    c_d     = c_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = exp_i;
          mod_d   = p_i;
          mask_d  = r_i;
          busy_d  = 1'b1;
          if (p_i != '0) begin
            state_d = S_CALC;
            rem_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_ZERO;
          end
        end
      end

      S_CALC: begin
        rem_d   = rem_nxt;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          k_d     = DW'(rem_nxt);
          c_d     = DW'(rem_nxt) ^ mask_q;
          done_d  = 1'b1;
          err_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_ZERO: begin
        k_d     = '0;
        c_d     = mask_q;
        err_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers: no input-to-output path.
  always_comb begin
    busy = busy_q;
    done = done_q;
    err  = err_q;
    k_o  = k_q;
    c_o  = c_q;
  end

endmodule

// File: tb/tb_enc_mod_xor_seq.sv
module tb_enc_mod_xor_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] exp_i;
  logic [31:0] p_i;
  logic [63:0] r_i;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] k_o;
  logic [63:0] c_o;

  int vectors = 0;
  int miscompares = 0;

  // Results the DUT should be holding between completions
  logic [63:0] last_k;
  logic [63:0] last_c;
  logic        last_err;

  always #5 clk = ~clk;

  enc_mod_xor_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .exp_i (exp_i),
    .p_i   (p_i),
    .r_i   (r_i),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .k_o   (k_o),
    .c_o   (c_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one request at the current negedge (idle or done cycle), optionally
  // poke a second start mid-reduction, then wait for and check the result.
  task automatic run(input logic [63:0] e, input logic [31:0] p,
                     input logic [63:0] r, input int poke_at);
    int          n;
    logic [63:0] kexp;
    kexp  = (p == 32'd0) ? 64'd0 : (e % {32'd0, p});
    start = 1'b1;
    exp_i = e;
    p_i   = p;
    r_i   = r;
    @(negedge clk);
    start = 1'b0;
    exp_i = {$urandom, $urandom};
    p_i   = $urandom;
    r_i   = {$urandom, $urandom};
    chk("done_width", 64'(done), 64'd0);
    chk("busy_set", 64'(busy), 64'd1);
    chk("k_hold", k_o, last_k);
    chk("c_hold", c_o, last_c);
    chk("err_hold", 64'(err), 64'(last_err));
    n = 0;
    if (poke_at > 0) begin
      repeat (poke_at) begin
        @(negedge clk);
        n++;
      end
      start = 1'b1;
      exp_i = 64'hDEAD_BEEF_0BAD_F00D;
      p_i   = 32'd3;
      r_i   = 64'h5555;
      @(negedge clk);
      n++;
      start = 1'b0;
    end
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), (p == 32'd0) ? 64'd1 : 64'd64);
    chk("k_o", k_o, kexp);
    chk("c_o", c_o, kexp ^ r);
    chk("err", 64'(err), (p == 32'd0) ? 64'd1 : 64'd0);
    chk("busy_clr", 64'(busy), 64'd0);
    last_k   = kexp;
    last_c   = kexp ^ r;
    last_err = (p == 32'd0);
  endtask

  initial begin
    int          seen;
    int          sel;
    logic [63:0] e;
    logic [31:0] p;
    logic [63:0] r;

    rst   = 1'b1;
    start = 1'b0;
    exp_i = 64'd0;
    p_i   = 32'd0;
    r_i   = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_k", k_o, 64'd0);
    chk("rst_c", c_o, 64'd0);
    rst      = 1'b0;
    last_k   = 64'd0;
    last_c   = 64'd0;
    last_err = 1'b0;

    // Directed cases
    run(64'd100, 32'd7, 64'hFF, 0);
    run(64'd5, 32'd7, 64'd0, 0);
    run(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'hA5, 0);
    run(64'd123, 32'd0, 64'h1234, 0);
    run(64'd1000, 32'd13, 64'h0F0F, 0);      // err held during busy, then cleared
    run(64'h0123_4567_89AB_CDEF, 32'd1, 64'h77, 0);
    run(64'h0123_4567_89AB_CDEF, 32'd97, 64'h1, 10);  // ignored mid-CALC start
    run(64'hFEDC_BA98_7654_3210, 32'h8000_0001, 64'h3C, 0);  // back-to-back

    // Reset during reduction
    @(negedge clk);
    start = 1'b1;
    exp_i = 64'hFFFF_0000_1234_5678;
    p_i   = 32'd1009;
    r_i   = 64'hAAAA;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_k", k_o, 64'd0);
    chk("midrst_c", c_o, 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);
    last_k   = 64'd0;
    last_c   = 64'd0;
    last_err = 1'b0;

    // Random back-to-back traffic against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      sel = int'($urandom_range(0, 7));
      e   = {$urandom, $urandom};
      p   = $urandom;
      r   = {$urandom, $urandom};
      case (sel)
        0: p = 32'd0;
        1: p = 32'd1;
        2: p = 32'hFFFF_FFFF;
        3: e = 64'd0;
        4: e = {32'd0, 32'($urandom_range(0, 1000))};
        5: p = 32'($urandom_range(1, 255));
        default: ;
      endcase
      run(e, p, r, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
